// File: rtl/fight_pkg.sv
// fight_pkg: player state encodings, combat
// constants and match-result encodings.
package fight_pkg;

  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_WALK_FWD      = 4'd1,
    ST_WALK_BACK     = 4'd2,
    ST_B_ATTACK      = 4'd3,
    ST_B_ATTACK_END  = 4'd4,
    ST_B_ATTACK_PULL = 4'd5,
    ST_D_ATTACK      = 4'd6,
    ST_D_ATTACK_MID  = 4'd7,
    ST_D_ATTACK_END  = 4'd8,
    ST_D_ATTACK_PULL = 4'd9
  } player_st_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  typedef enum logic {
    FIGHT = 1'b0,
    KO    = 1'b1
  } match_st_e;

  typedef struct packed {
    logic [9:0] x1;
    logic [9:0] x2;
    logic [9:0] y1;
    logic [9:0] y2;
  } box_t;

  localparam logic [6:0] HEALTH_MAX_C = 7'd100;
  localparam logic [6:0] BASIC_DMG_C  = 7'd10;
  localparam logic [6:0] DIR_DMG_C    = 7'd15;
  localparam logic [7:0] STUN_C       = 8'd12;
  localparam logic [3:0] BASIC_ACT_C  = 4'd4;
  localparam logic [3:0] DIR_ACT_C    = 4'd8;

  function automatic logic [6:0] sat_sub(
    input logic [6:0] a,
    input logic [6:0] b
  );
    return (a > b) ? a - b : 7'd0;
  endfunction

endpackage

// File: rtl/box_overlap.sv
// box_overlap: inclusive overlap test of two
// boxes whose corners may be given in any order.
module box_overlap
  import fight_pkg::*;
(
  input  box_t a,
  input  box_t b,
  output logic hit
);

  logic [9:0] ax_lo, ax_hi, ay_lo, ay_hi;
  logic [9:0] bx_lo, bx_hi, by_lo, by_hi;

  // normalise corners, then touching edges count
  always_comb begin
    ax_lo = (a.x1 < a.x2) ? a.x1 : a.x2;
    ax_hi = (a.x1 < a.x2) ? a.x2 : a.x1;
    ay_lo = (a.y1 < a.y2) ? a.y1 : a.y2;
    ay_hi = (a.y1 < a.y2) ? a.y2 : a.y1;
    bx_lo = (b.x1 < b.x2) ? b.x1 : b.x2;
    bx_hi = (b.x1 < b.x2) ? b.x2 : b.x1;
    by_lo = (b.y1 < b.y2) ? b.y1 : b.y2;
    by_hi = (b.y1 < b.y2) ? b.y2 : b.y1;
    hit = (ax_lo <= bx_hi) && (bx_lo <= ax_hi)
       && (ay_lo <= by_hi) && (by_lo <= ay_hi);
  end

endmodule

// File: rtl/hit_resolver.sv
// hit_resolver: turns attack/hurtbox overlaps
// into hits, health, hitstun and round result.
module hit_resolver
  import fight_pkg::*;
#(
  parameter logic [6:0] HEALTH_MAX      = HEALTH_MAX_C,
  parameter logic [6:0] BASIC_DMG       = BASIC_DMG_C,
  parameter logic [6:0] DIR_DMG         = DIR_DMG_C,
  parameter logic [7:0] STUN_CYCLES     = STUN_C,
  parameter logic [3:0] BASIC_ACTIVE_ST = BASIC_ACT_C,
  parameter logic [3:0] DIR_ACTIVE_ST   = DIR_ACT_C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [3:0] p1_state,
  input  logic [3:0] p2_state,
  input  logic [9:0] p1_basic_x1,
  input  logic [9:0] p1_basic_x2,
  input  logic [9:0] p1_basic_y1,
  input  logic [9:0] p1_basic_y2,
  input  logic [9:0] p1_dir_x1,
  input  logic [9:0] p1_dir_x2,
  input  logic [9:0] p1_dir_y1,
  input  logic [9:0] p1_dir_y2,
  input  logic [9:0] p1_hurt_x1,
  input  logic [9:0] p1_hurt_x2,
  input  logic [9:0] p1_hurt_y1,
  input  logic [9:0] p1_hurt_y2,
  input  logic [9:0] p2_basic_x1,
  input  logic [9:0] p2_basic_x2,
  input  logic [9:0] p2_basic_y1,
  input  logic [9:0] p2_basic_y2,
  input  logic [9:0] p2_dir_x1,
  input  logic [9:0] p2_dir_x2,
  input  logic [9:0] p2_dir_y1,
  input  logic [9:0] p2_dir_y2,
  input  logic [9:0] p2_hurt_x1,
  input  logic [9:0] p2_hurt_x2,
  input  logic [9:0] p2_hurt_y1,
  input  logic [9:0] p2_hurt_y2,
  output logic [6:0] p1_health,
  output logic [6:0] p2_health,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       p1_stun,
  output logic       p2_stun,
  output logic       game_over,
  output logic [1:0] winner
);

  box_t b1_basic, b1_dir, b1_hurt;
  box_t b2_basic, b2_dir, b2_hurt;

  assign b1_basic = {p1_basic_x1, p1_basic_x2,
                     p1_basic_y1, p1_basic_y2};
  assign b1_dir   = {p1_dir_x1, p1_dir_x2,
                     p1_dir_y1, p1_dir_y2};
  assign b1_hurt  = {p1_hurt_x1, p1_hurt_x2,
                     p1_hurt_y1, p1_hurt_y2};
  assign b2_basic = {p2_basic_x1, p2_basic_x2,
                     p2_basic_y1, p2_basic_y2};
  assign b2_dir   = {p2_dir_x1, p2_dir_x2,
                     p2_dir_y1, p2_dir_y2};
  assign b2_hurt  = {p2_hurt_x1, p2_hurt_x2,
                     p2_hurt_y1, p2_hurt_y2};

  logic ov_b12, ov_d12, ov_b21, ov_d21;

  box_overlap u_b12 (.a(b1_basic), .b(b2_hurt), .hit(ov_b12));
  box_overlap u_d12 (.a(b1_dir),   .b(b2_hurt), .hit(ov_d12));
  box_overlap u_b21 (.a(b2_basic), .b(b1_hurt), .hit(ov_b21));
  box_overlap u_d21 (.a(b2_dir),   .b(b1_hurt), .hit(ov_d21));

  match_st_e  state_q, state_d;
  winner_e    win_q;
  logic       landed1, landed2;
  logic [7:0] cnt1, cnt2;

  logic       b1_on, d1_on, b2_on, d2_on;
  logic       fire12, fire21;
  logic [6:0] dmg12, dmg21;

  assign b1_on = (p1_state == BASIC_ACTIVE_ST);
  assign d1_on = (p1_state == DIR_ACTIVE_ST);
  assign b2_on = (p2_state == BASIC_ACTIVE_ST);
  assign d2_on = (p2_state == DIR_ACTIVE_ST);

  assign dmg12 = d1_on ? DIR_DMG : BASIC_DMG;
  assign dmg21 = d2_on ? DIR_DMG : BASIC_DMG;

  // a strike counts once per attack and only mid-round
  assign fire12 = (state_q == FIGHT) && !landed1
               && ((b1_on && ov_b12) || (d1_on && ov_d12));
  assign fire21 = (state_q == FIGHT) && !landed2
               && ((b2_on && ov_b21) || (d2_on && ov_d21));

  assign p1_stun   = (cnt1 != 8'd0);
  assign p2_stun   = (cnt2 != 8'd0);
  assign game_over = (state_q == KO);
  assign winner    = win_q;

  // round state: KO once a bar is empty, back on restart
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FIGHT: if (p1_health == 7'd0 || p2_health == 7'd0)
               state_d = KO;
      KO:    if (restart) state_d = FIGHT;
      default: state_d = FIGHT;
    endcase
  end

  // round state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FIGHT;
    else      state_q <= state_d;
  end

  // health, hit pulses, landed flags, stun and result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_health <= HEALTH_MAX;
      p2_health <= HEALTH_MAX;
      p1_hit    <= 1'b0;
      p2_hit    <= 1'b0;
      landed1   <= 1'b0;
      landed2   <= 1'b0;
      cnt1      <= 8'd0;
      cnt2      <= 8'd0;
      win_q     <= WIN_NONE;
    end else if (state_q == KO) begin
      p1_hit <= 1'b0;
      p2_hit <= 1'b0;
      cnt1   <= (cnt1 != 8'd0) ? cnt1 - 8'd1 : cnt1;
      cnt2   <= (cnt2 != 8'd0) ? cnt2 - 8'd1 : cnt2;
      if (restart) begin
        p1_health <= HEALTH_MAX;
        p2_health <= HEALTH_MAX;
        landed1   <= 1'b0;
        landed2   <= 1'b0;
        cnt1      <= 8'd0;
        cnt2      <= 8'd0;
        win_q     <= WIN_NONE;
      end
    end else begin
      p1_hit  <= fire21;
      p2_hit  <= fire12;
      landed1 <= (b1_on || d1_on) && (landed1 || fire12);
      landed2 <= (b2_on || d2_on) && (landed2 || fire21);
      if (fire21) p1_health <= sat_sub(p1_health, dmg21);
      if (fire12) p2_health <= sat_sub(p2_health, dmg12);
      if (fire21)            cnt1 <= STUN_CYCLES;
      else if (cnt1 != 8'd0) cnt1 <= cnt1 - 8'd1;
      if (fire12)            cnt2 <= STUN_CYCLES;
      else if (cnt2 != 8'd0) cnt2 <= cnt2 - 8'd1;
      if (state_d == KO) begin
        if (p1_health != 7'd0)      win_q <= WIN_P1;
        else if (p2_health != 7'd0) win_q <= WIN_P2;
        else                        win_q <= WIN_DRAW;
      end
    end
  end

endmodule

// File: tb/tb_hit_resolver.sv
// tb_hit_resolver: scenario tasks push expected
// output snapshots and compare them per cycle.
module tb_hit_resolver;

  logic       clk = 1'b0;
  logic       rst, restart;
  logic [3:0] p1_state, p2_state;
  logic [9:0] p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2;
  logic [9:0] p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2;
  logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
  logic [9:0] p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2;
  logic [9:0] p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2;
  logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
  logic [6:0] p1_health, p2_health;
  logic       p1_hit, p2_hit, p1_stun, p2_stun, game_over;
  logic [1:0] winner;

  int n_cmp = 0;
  int n_bad = 0;
  logic [20:0] exp_q[$];
  logic [20:0] e;
  logic [20:0] obs;

  assign obs = {p1_health, p2_health, p1_hit, p2_hit,
                p1_stun, p2_stun, game_over, winner};

  always #5 clk = ~clk;

  hit_resolver dut (
    .clk(clk), .rst(rst), .restart(restart),
    .p1_state(p1_state), .p2_state(p2_state),
    .p1_basic_x1(p1_basic_x1), .p1_basic_x2(p1_basic_x2),
    .p1_basic_y1(p1_basic_y1), .p1_basic_y2(p1_basic_y2),
    .p1_dir_x1(p1_dir_x1), .p1_dir_x2(p1_dir_x2),
    .p1_dir_y1(p1_dir_y1), .p1_dir_y2(p1_dir_y2),
    .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2),
    .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
    .p2_basic_x1(p2_basic_x1), .p2_basic_x2(p2_basic_x2),
    .p2_basic_y1(p2_basic_y1), .p2_basic_y2(p2_basic_y2),
    .p2_dir_x1(p2_dir_x1), .p2_dir_x2(p2_dir_x2),
    .p2_dir_y1(p2_dir_y1), .p2_dir_y2(p2_dir_y2),
    .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2),
    .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_hit(p1_hit), .p2_hit(p2_hit),
    .p1_stun(p1_stun), .p2_stun(p2_stun),
    .game_over(game_over), .winner(winner)
  );

  function automatic logic [20:0] mk(
    input int h1, input int h2,
    input bit t1, input bit t2,
    input bit s1, input bit s2,
    input bit go, input logic [1:0] w
  );
    logic [6:0] a, b;
    a = h1[6:0];
    b = h2[6:0];
    return {a, b, t1, t2, s1, s2, go, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic place_default();
    p1_hurt_x1 = 100; p1_hurt_x2 = 150;
    p1_hurt_y1 = 0;   p1_hurt_y2 = 100;
    p2_hurt_x1 = 550; p2_hurt_x2 = 500;
    p2_hurt_y1 = 0;   p2_hurt_y2 = 100;
    p1_basic_x1 = 200; p1_basic_x2 = 210;
    p1_basic_y1 = 0;   p1_basic_y2 = 100;
    p1_dir_x1 = 220; p1_dir_x2 = 230;
    p1_dir_y1 = 0;   p1_dir_y2 = 100;
    p2_basic_x1 = 400; p2_basic_x2 = 410;
    p2_basic_y1 = 0;   p2_basic_y2 = 100;
    p2_dir_x1 = 380; p2_dir_x2 = 390;
    p2_dir_y1 = 0;   p2_dir_y2 = 100;
  endtask

  task automatic do_reset();
    restart = 0;
    p1_state = 0;
    p2_state = 0;
    place_default();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    #2;
    exp_q.push_back(mk(100, 100, 0, 0, 0, 0, 0, 2'b00));
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL reset_val got=%h exp=%h", obs, e);
    end
    tick();
    tick();
    rst = 1;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(mk(100, 100, 0, 0, 0, 0, 0, 2'b00));
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL idle[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    p1_basic_x1 = 490; p1_basic_x2 = 505;
    p1_state = 4;
    exp_q.push_back(mk(100, 90, 0, 1, 0, 1, 0, 2'b00));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL basic_hit got=%h exp=%h", obs, e);
    end
    exp_q.push_back(mk(100, 90, 0, 0, 0, 1, 0, 2'b00));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL basic_hold got=%h exp=%h", obs, e);
    end
    p1_state = 0;
    for (int i = 2; i <= 12; i++) begin
      restart = (i == 3);
      exp_q.push_back(mk(100, 90, 0, 0, 0, i < 12, 0, 2'b00));
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL stun_drain[%0d] got=%h exp=%h", i, obs, e);
      end
    end
    restart = 0;
    p1_state = 5;
    exp_q.push_back(mk(100, 90, 0, 0, 0, 0, 0, 2'b00));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL pull_nohit got=%h exp=%h", obs, e);
    end
    p1_state = 4;
    exp_q.push_back(mk(100, 80, 0, 1, 0, 1, 0, 2'b00));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL rehit got=%h exp=%h", obs, e);
    end
    p1_state = 0;
    for (int i = 1; i <= 12; i++) begin
      exp_q.push_back(mk(100, 80, 0, 0, 0, i < 12, 0, 2'b00));
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL rehit_drain[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_reversed_box();
    do_reset();
    p2_hurt_x1 = 501; p2_hurt_x2 = 448;
    p1_basic_x1 = 445; p1_basic_x2 = 450;
    p1_state = 4;
    exp_q.push_back(mk(100, 90, 0, 1, 0, 1, 0, 2'b00));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL rev_hit got=%h exp=%h", obs, e);
    end
    p1_state = 0;
    for (int i = 1; i <= 12; i++) begin
      exp_q.push_back(mk(100, 90, 0, 0, 0, i < 12, 0, 2'b00));
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL rev_drain[%0d] got=%h exp=%h", i, obs, e);
      end
    end
    p1_basic_x2 = 448;
    p1_state = 4;
    exp_q.push_back(mk(100, 80, 0, 1, 0, 1, 0, 2'b00));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL touch_hit got=%h exp=%h", obs, e);
    end
    p1_state = 0;
    for (int i = 1; i <= 12; i++) begin
      exp_q.push_back(mk(100, 80, 0, 0, 0, i < 12, 0, 2'b00));
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL touch_drain[%0d] got=%h exp=%h", i, obs, e);
      end
    end
    p1_basic_x2 = 447;
    p1_state = 4;
    exp_q.push_back(mk(100, 80, 0, 0, 0, 0, 0, 2'b00));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL gap_nohit got=%h exp=%h", obs, e);
    end
    p1_state = 0;
  endtask

  task automatic test_trade();
    do_reset();
    p1_basic_x1 = 490; p1_basic_x2 = 505;
    p2_basic_x1 = 140; p2_basic_x2 = 160;
    p1_state = 4;
    p2_state = 4;
    exp_q.push_back(mk(90, 90, 1, 1, 1, 1, 0, 2'b00));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL trade got=%h exp=%h", obs, e);
    end
    p1_state = 0;
    p2_state = 0;
    for (int i = 1; i <= 12; i++) begin
      exp_q.push_back(mk(90, 90, 0, 0, i < 12, i < 12, 0, 2'b00));
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL trade_drain[%0d] got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_ko();
    int h2;
    int h;
    do_reset();
    p1_basic_x1 = 490; p1_basic_x2 = 505;
    p1_dir_x1 = 540;   p1_dir_x2 = 560;
    h2 = 100;
    for (int k = 0; k < 7; k++) begin
      p1_state = (k < 5) ? 4'd8 : 4'd4;
      h2 = h2 - ((k < 5) ? 15 : 10);
      exp_q.push_back(mk(100, h2, 0, 1, 0, 1, 0, 2'b00));
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL ko_ramp[%0d] got=%h exp=%h", k, obs, e);
      end
      p1_state = 0;
      exp_q.push_back(mk(100, h2, 0, 0, 0, 1, 0, 2'b00));
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL ko_gap[%0d] got=%h exp=%h", k, obs, e);
      end
    end
    p1_state = 8;
    exp_q.push_back(mk(100, 0, 0, 1, 0, 1, 0, 2'b00));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL ko_sat got=%h exp=%h", obs, e);
    end
    exp_q.push_back(mk(100, 0, 0, 0, 0, 1, 1, 2'b01));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL ko_enter got=%h exp=%h", obs, e);
    end
    p1_state = 0;
    exp_q.push_back(mk(100, 0, 0, 0, 0, 1, 1, 2'b01));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL ko_idle got=%h exp=%h", obs, e);
    end
    p1_state = 4;
    p2_state = 4;
    p2_basic_x1 = 140; p2_basic_x2 = 160;
    for (int j = 3; j <= 5; j++) begin
      exp_q.push_back(mk(100, 0, 0, 0, 0, 1, 1, 2'b01));
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL ko_ignore[%0d] got=%h exp=%h", j, obs, e);
      end
    end
    p1_state = 0;
    p2_state = 0;
    restart = 1;
    exp_q.push_back(mk(100, 100, 0, 0, 0, 0, 0, 2'b00));
    tick();
    restart = 0;
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL restart got=%h exp=%h", obs, e);
    end
    p2_dir_x1 = 101; p2_dir_x2 = 90;
    for (int k = 0; k < 6; k++) begin
      h = 100 - 15 * (k + 1);
      p1_state = 8;
      p2_state = 8;
      exp_q.push_back(mk(h, h, 1, 1, 1, 1, 0, 2'b00));
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL mutual_ramp[%0d] got=%h exp=%h", k, obs, e);
      end
      p1_state = 0;
      p2_state = 0;
      exp_q.push_back(mk(h, h, 0, 0, 1, 1, 0, 2'b00));
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL mutual_gap[%0d] got=%h exp=%h", k, obs, e);
      end
    end
    p1_state = 4;
    p2_state = 4;
    exp_q.push_back(mk(0, 0, 1, 1, 1, 1, 0, 2'b00));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL mutual_ko got=%h exp=%h", obs, e);
    end
    p1_state = 0;
    p2_state = 0;
    exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 1, 2'b11));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL draw got=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 0;
    #1;
    exp_q.push_back(mk(100, 100, 0, 0, 0, 0, 0, 2'b00));
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL rst_ko got=%h exp=%h", obs, e);
    end
    #2;
    rst = 1;
    p1_state = 0;
    p2_state = 0;
    place_default();
    p1_basic_x1 = 490; p1_basic_x2 = 505;
    tick();
    p1_state = 4;
    exp_q.push_back(mk(100, 90, 0, 1, 0, 1, 0, 2'b00));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL pre_rst_hit got=%h exp=%h", obs, e);
    end
    p1_state = 0;
    #2;
    rst = 0;
    #1;
    exp_q.push_back(mk(100, 100, 0, 0, 0, 0, 0, 2'b00));
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL rst_stun got=%h exp=%h", obs, e);
    end
    #2;
    rst = 1;
    exp_q.push_back(mk(100, 100, 0, 0, 0, 0, 0, 2'b00));
    tick();
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL post_rst got=%h exp=%h", obs, e);
    end
  endtask

  initial begin
    rst = 1;
    restart = 0;
    p1_state = 0;
    p2_state = 0;
    place_default();
    #1;
    rst = 0;
    test_reset();
    test_basic();
    test_reversed_box();
    test_trade();
    test_ko();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
